serial_half_adder_acc: RTL and testbench

Bit-serial adder stage that feeds the team's half-adder cell design. It captures two WIDTH-bit operands on a start handshake and adds them LSB-first over WIDTH clock cycles. Each bit uses two half-adder cells plus a registered carry. The result, carry-out and a done pulse are presented to the top-level output mapping (uo_out/uio_out) of the tt_um user project.

---
 rtl/serial_half_adder_acc.sv | 119 +++++++++++
 tb/tb_serial_half_adder_acc.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_half_adder_acc.sv
// Bit-serial adder: captures WIDTH-bit operands on start and adds them LSB-first, one bit per cycle.
// Latency: WIDTH cycles from the accepting edge to the done pulse; one addition per WIDTH+1 cycles.
// Backpressure: none; ena=0 freezes all state, start is ignored while busy. Optional: SERIAL_ADD_SAT_EN.
module serial_half_adder_acc #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic [WIDTH-1:0]  sum_q, sum_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              carry_q, carry_d;
    logic              cout_q, cout_d;

    // Two chained half-adder cells on the current LSBs plus the registered carry
    logic s1, c1, s2, c2, carry_nxt;
    always_comb begin
        s1        = a_q[0] ^ b_q[0];
        c1        = a_q[0] & b_q[0];
        s2        = s1 ^ carry_q;
        c2        = s1 & carry_q;
        carry_nxt = c1 | c2;
    end

    // Next-state and datapath update; everything holds while ena is low
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        if (ena) begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        a_d     = a;
                        b_d     = b;
                        carry_d = 1'b0;
                        cnt_d   = '0;
                        sum_d   = '0;
                        cout_d  = 1'b0;
                        state_d = RUN;
                    end else begin
                        state_d = IDLE;
                    end
                end
                RUN: begin
                    sum_d   = {s2, sum_q[WIDTH-1:1]};
                    carry_d = carry_nxt;
                    a_d     = a_q >> 1;
                    b_d     = b_q >> 1;
                    cnt_d   = cnt_q + 1'b1;
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        state_d = DONE;
                        cout_d  = carry_nxt;
`ifdef SERIAL_ADD_SAT_EN
                        // Overflow clamps the result to the maximum value
                        if (carry_nxt) begin
                            sum_d = '1;
                        end
`endif
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State registers, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
        end
    end

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_serial_half_adder_acc.sv
// Testbench for serial_half_adder_acc: WIDTH=8 and WIDTH=4 instances against an arithmetic reference.
// Inputs driven 1ns after the rising edge, outputs sampled before the next edge.
// Honours SERIAL_ADD_SAT_EN in the reference model.
module tb_serial_half_adder_acc;

    logic       clk = 1'b0;
    logic       rst_n, ena, start;
    logic [7:0] a, b, sum;
    logic       busy, done, cout;

    logic       ena4, start4;
    logic [3:0] a4, b4, sum4;
    logic       busy4, done4, cout4;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    serial_half_adder_acc #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .start(start), .a(a), .b(b),
        .busy(busy), .done(done), .sum(sum), .cout(cout)
    );

    serial_half_adder_acc #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .ena(ena4), .start(start4), .a(a4), .b(b4),
        .busy(busy4), .done(done4), .sum(sum4), .cout(cout4)
    );

    // Reference: plain unsigned addition, optionally clamped on overflow
    function automatic void ref_add(input int w, input int x, input int y,
                                    output int es, output int ec);
        int t;
        t  = x + y;
        es = t % (1 << w);
        ec = (t >> w) & 1;
`ifdef SERIAL_ADD_SAT_EN
        if (ec == 1) es = (1 << w) - 1;
`endif
    endfunction

    // Drive one addition on the 8-bit instance; return edges until done and busy samples
    task automatic do_add(input logic [7:0] x, input logic [7:0] y,
                          output int cyc, output int busy_cnt);
        a = x; b = y; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 0; busy_cnt = 0;
        while (done !== 1'b1 && cyc < 200) begin
            if (busy === 1'b1) busy_cnt++;
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; ena = 1'b1; start = 1'b0; a = '0; b = '0;
        ena4 = 1'b1; start4 = 1'b0; a4 = '0; b4 = '0;
        #13;
        checks++;
        if ({busy, done, sum, cout} !== 11'd0) begin
            errors++;
            $display("FAIL reset8: got busy=%b done=%b sum=%0d cout=%b, want all 0", busy, done, sum, cout);
        end
        checks++;
        if ({busy4, done4, sum4, cout4} !== 7'd0) begin
            errors++;
            $display("FAIL reset4: got busy=%b done=%b sum=%0d cout=%b, want all 0", busy4, done4, sum4, cout4);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        int cyc, bc, es, ec;
        ref_add(8, 3, 5, es, ec);
        do_add(8'd3, 8'd5, cyc, bc);
        checks++;
        if (cyc !== 8 || bc !== 8) begin
            errors++;
            $display("FAIL basic_timing: got latency=%0d busy=%0d, want 8 and 8", cyc, bc);
        end
        checks++;
        if (sum !== es[7:0] || cout !== ec[0] || busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_result: got sum=%0d cout=%b busy=%b, want sum=%0d cout=%0d busy=0", sum, cout, busy, es, ec);
        end
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b0 || sum !== es[7:0]) begin
            errors++;
            $display("FAIL basic_hold1: got done=%b sum=%0d, want done=0 sum=%0d", done, sum, es);
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (sum !== es[7:0] || cout !== ec[0] || done !== 1'b0) begin
            errors++;
            $display("FAIL basic_hold4: got sum=%0d cout=%b done=%b, want sum=%0d cout=%0d done=0", sum, cout, done, es, ec);
        end
    endtask

    task automatic test_overflow();
        int cyc, bc, es, ec;
        ref_add(8, 255, 1, es, ec);
        do_add(8'd255, 8'd1, cyc, bc);
        checks++;
        if (cyc !== 8 || sum !== es[7:0] || cout !== ec[0]) begin
            errors++;
            $display("FAIL overflow: got lat=%0d sum=%0d cout=%b, want lat=8 sum=%0d cout=%0d", cyc, sum, cout, es, ec);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        int cyc, bc, es, ec, x, y;
        for (int i = 0; i < 10; i++) begin
            x = int'($urandom_range(0, 255));
            y = int'($urandom_range(0, 255));
            ref_add(8, x, y, es, ec);
            do_add(x[7:0], y[7:0], cyc, bc);
            checks++;
            if (cyc !== 8 || sum !== es[7:0] || cout !== ec[0]) begin
                errors++;
                $display("FAIL random_%0d: %0d+%0d got lat=%0d sum=%0d cout=%b, want lat=8 sum=%0d cout=%0d",
                         i, x, y, cyc, sum, cout, es, ec);
            end
            if ($urandom_range(0, 1) == 1) begin
                @(posedge clk); #1;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        int xs[4], ys[4], es, ec, dcount;
        xs[0] = 200; ys[0] = 100;
        for (int i = 1; i < 4; i++) begin
            xs[i] = int'($urandom_range(0, 255));
            ys[i] = int'($urandom_range(0, 255));
        end
        a = xs[0][7:0]; b = ys[0][7:0]; start = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            // Operands change mid-run; they become the next accepted pair
            if (i < 3) begin
                a = xs[i+1][7:0]; b = ys[i+1][7:0];
            end else begin
                a = 8'hA5; b = 8'h5A; start = 1'b0;
            end
            dcount = 0;
            for (int k = 1; k <= 8; k++) begin
                @(posedge clk); #1;
                if (done === 1'b1) dcount++;
            end
            ref_add(8, xs[i], ys[i], es, ec);
            checks++;
            if (done !== 1'b1 || dcount !== 1 || sum !== es[7:0] || cout !== ec[0]) begin
                errors++;
                $display("FAIL b2b_%0d: got done=%b pulses=%0d sum=%0d cout=%b, want done=1 pulses=1 sum=%0d cout=%0d",
                         i, done, dcount, sum, cout, es, ec);
            end
        end
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL b2b_idle: got busy=%b done=%b, want 0 0", busy, done);
        end
    endtask

    task automatic test_stall();
        int cyc, es, ec, frozen_err;
        logic [7:0] held;
        ref_add(8, 170, 85, es, ec);
        a = 8'd170; b = 8'd85; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        held = sum;
        ena = 1'b0;
        frozen_err = 0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            if (sum !== held || busy !== 1'b1 || done !== 1'b0) frozen_err++;
        end
        ena = 1'b1;
        checks++;
        if (frozen_err !== 0) begin
            errors++;
            $display("FAIL stall_frozen: got %0d changed cycles, want 0", frozen_err);
        end
        cyc = 5;
        while (done !== 1'b1 && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
        checks++;
        if (cyc !== 11 || sum !== es[7:0] || cout !== ec[0]) begin
            errors++;
            $display("FAIL stall_result: got lat=%0d sum=%0d cout=%b, want lat=11 sum=%0d cout=%0d", cyc, sum, cout, es, ec);
        end
        // done is held while ena is low
        ena = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL stall_done_hold: got done=%b, want 1", done);
        end
        ena = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        int cyc, bc, es, ec;
        a = 8'd255; b = 8'd255; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (sum !== 8'hE0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL mid_partial: got sum=%h busy=%b, want sum=e0 busy=1", sum, busy);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, sum, cout} !== 11'd0) begin
            errors++;
            $display("FAIL mid_async_reset: got busy=%b done=%b sum=%0d cout=%b, want all 0", busy, done, sum, cout);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL mid_idle: got busy=%b done=%b, want 0 0", busy, done);
        end
        ref_add(8, 1, 1, es, ec);
        do_add(8'd1, 8'd1, cyc, bc);
        checks++;
        if (cyc !== 8 || sum !== es[7:0] || cout !== ec[0]) begin
            errors++;
            $display("FAIL mid_rerun: got lat=%0d sum=%0d cout=%b, want lat=8 sum=%0d cout=%0d", cyc, sum, cout, es, ec);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_width4();
        int cyc, es, ec;
        ref_add(4, 15, 15, es, ec);
        a4 = 4'd15; b4 = 4'd15; start4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0;
        cyc = 0;
        while (done4 !== 1'b1 && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
        checks++;
        if (cyc !== 4 || sum4 !== es[3:0] || cout4 !== ec[0]) begin
            errors++;
            $display("FAIL width4: got lat=%0d sum=%0d cout=%b, want lat=4 sum=%0d cout=%0d", cyc, sum4, cout4, es, ec);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_random();
        test_back_to_back();
        test_stall();
        test_reset_mid();
        test_width4();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
